bit_serial_adder: RTL and testbench

- Multi-bit adder that reuses the one-bit full_adder cell over WIDTH clock cycles, LSB first.
- A carry flip-flop closes the loop between bit slices.
- Sits directly upstream of full_adder: shift registers feed its a/b/cin and capture its sum/c_out.
- Area-cheap alternative to a ripple array for slow datapaths; results are handed to downstream logic through a start/done handshake.

---
 rtl/bsa_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/bit_serial_adder.sv | 113 +++++++++++
 tb/tb_bit_serial_adder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package bsa_pkg;

    localparam int BSA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell reused by the bit-serial adder for every bit slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ cin;
    assign c_out = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// WIDTH-bit adder computed LSB first over WIDTH cycles through one full_adder.
// Define BIT_SERIAL_ADDER_OVF_EN to add the signed overflow output ovf.
module bit_serial_adder
    import bsa_pkg::*;
#(
    parameter int WIDTH = BSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             last;

    full_adder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .cin   (carry),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    assign last = (cnt == LAST);
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (last) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    sum   <= {fa_sum, sum[WIDTH-1:1]};
                    carry <= fa_cout;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    // hold on the last slice so the count never wraps
                    if (last) begin
                        cout <= fa_cout;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BIT_SERIAL_ADDER_OVF_EN
    // carry flop holds the carry into the MSB during the last slice
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == ST_RUN && last) begin
            ovf <= carry ^ fa_cout;
        end
    end
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8) against an arithmetic model.
module tb_bit_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       cin_in;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int checks;
    int errors;
    int done_cnt;
    int cyc;
    int last_done_cyc;

    bit_serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_in),
        .b     (b_in),
        .cin   (cin_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef BIT_SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] ref_add(input logic [7:0] x,
                                           input logic [7:0] y,
                                           input logic c);
        int s;
        s = int'(x) + int'(y) + int'(c);
        return s[8:0];
    endfunction

    function automatic logic ref_ovf(input logic [7:0] x,
                                     input logic [7:0] y,
                                     input logic c);
        int sx, sy, s;
        sx = int'($signed(x));
        sy = int'($signed(y));
        s = sx + sy + int'(c);
        return (s > 127) || (s < -128);
    endfunction

    task automatic check_result(input string tag, input logic [7:0] x,
                                input logic [7:0] y, input logic c);
        logic [8:0] r;
        r = ref_add(x, y, c);
        check({tag, "_sum"}, 32'(sum), 32'(r[7:0]));
        check({tag, "_cout"}, 32'(cout), 32'(r[8]));
`ifdef BIT_SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(x, y, c)));
`endif
    endtask

    // poke1/poke2: RUN edges (1..9) at which a spurious start is presented
    task automatic run_op(input string tag, input logic [7:0] x,
                          input logic [7:0] y, input logic c,
                          input int poke1, input int poke2);
        int d0;
        int busy_cycles;
        @(negedge clk);
        a_in = x;
        b_in = y;
        cin_in = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        d0 = done_cnt;
        start = 1'b0;
        a_in = 8'($urandom);
        b_in = 8'($urandom);
        cin_in = 1'($urandom);
        busy_cycles = busy ? 1 : 0;
        for (int i = 1; i <= 9; i++) begin
            if (i == poke1 || i == poke2) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (busy) busy_cycles++;
            if (i == 8) begin
                check({tag, "_done"}, 32'(done), 32'd1);
                check_result(tag, x, y, c);
            end
        end
        check({tag, "_busy_len"}, 32'(busy_cycles), 32'd8);
        check({tag, "_ndone"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check_result({tag, "_hold"}, x, y, c);
    endtask

    initial begin
        logic [7:0] cx, cy;
        logic cc;
        int d0;
        checks = 0;
        errors = 0;
        done_cnt = 0;
        cyc = 0;
        last_done_cyc = 0;
        start = 1'b0;
        a_in = '0;
        b_in = '0;
        cin_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
`ifdef BIT_SERIAL_ADDER_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_op("t5a3c", 8'h5A, 8'h3C, 1'b0, 0, 0);
        run_op("tff01", 8'hFF, 8'h01, 1'b0, 0, 0);
        run_op("tffff", 8'hFF, 8'hFF, 1'b1, 0, 0);
        run_op("tign", 8'h12, 8'h34, 1'b1, 3, 8);
        run_op("tign9", 8'hA5, 8'h0F, 1'b0, 9, 2);
        run_op("t7f01", 8'h7F, 8'h01, 1'b0, 0, 0);
        run_op("t8080", 8'h80, 8'h80, 1'b0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            run_op("trand", 8'($urandom), 8'($urandom), 1'($urandom), 0, 0);
        end

        // abort mid-RUN
        @(negedge clk);
        a_in = 8'hC3;
        b_in = 8'h77;
        cin_in = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_nodone", 32'(done_cnt - d0), 32'd0);
        run_op("t0101", 8'h01, 8'h01, 1'b0, 0, 0);

        // start held high: back-to-back operations on the corner cases
        @(negedge clk);
        start = 1'b1;
        d0 = done_cnt;
        for (int k = 0; k < 8; k++) begin
            cx = k[0] ? 8'hFF : 8'h00;
            cy = k[1] ? 8'hFF : 8'h00;
            cc = k[2];
            a_in = cx;
            b_in = cy;
            cin_in = cc;
            @(posedge clk);
            #1;
            check("held_busy", 32'(busy), 32'd1);
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            for (int j = 1; j <= 9; j++) begin
                @(posedge clk);
                #1;
                if (j == 8) begin
                    check("held_done", 32'(done), 32'd1);
                    check_result("held", cx, cy, cc);
                    if (k > 0) check("held_period", 32'(cyc - last_done_cyc), 32'd10);
                    last_done_cyc = cyc;
                end
            end
        end
        start = 1'b0;
        check("held_ndone", 32'(done_cnt - d0), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
